// File: rtl/datapath_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : datapath_seq_if
// Brief   : Micro-op handshake, completion and debug-tap bundle for datapath_seq.
// Revision: 1.0 - initial release
// ============================================================================
interface datapath_seq_if #(
    parameter int DW  = 16,
    parameter int RAW = 4,
    parameter int DAW = 8
);
    logic           Op_valid;
    logic           Op_ready;
    logic [1:0]     Op_code;
    logic [DAW-1:0] D_addr;
    logic [RAW-1:0] RF_W_addr;
    logic [RAW-1:0] RF_Ra_addr;
    logic [RAW-1:0] RF_Rb_addr;
    logic [2:0]     Alu_s;
    logic           Done;
    logic [1:0]     Flags;
    logic [DW-1:0]  ALU_A;
    logic [DW-1:0]  ALU_B;
    logic [DW-1:0]  ALU_Out;
    logic [DW-1:0]  RQ0;
    logic [DW-1:0]  Mux_out;

    modport master (
        output Op_valid, Op_code, D_addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s,
        input  Op_ready, Done, Flags, ALU_A, ALU_B, ALU_Out, RQ0, Mux_out
    );

    modport slave (
        input  Op_valid, Op_code, D_addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s,
        output Op_ready, Done, Flags, ALU_A, ALU_B, ALU_Out, RQ0, Mux_out
    );
endinterface
`default_nettype wire

// File: rtl/datapath_seq.sv
`default_nettype none
// ============================================================================
// Module  : datapath_seq
// Brief   : Sequenced datapath - register file, data RAM, writeback mux and
//           8-function ALU, one micro-op at a time over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module datapath_seq #(
    parameter int DW       = 16,
    parameter int RAW      = 4,
    parameter int DAW      = 8,
    parameter int ZERO_REG = 0
) (
    input wire            Clock,
    input wire            Reset,
    datapath_seq_if.slave bus
);

    localparam logic [1:0] C_OP_LOAD  = 2'b01;
    localparam logic [1:0] C_OP_STORE = 2'b10;
    localparam logic [1:0] C_OP_ALU   = 2'b11;
    localparam bit         C_ZERO_REG = (ZERO_REG != 0);
    localparam int         C_RF_DEPTH = 2 ** RAW;
    localparam int         C_RAM_DEPTH = 2 ** DAW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EX   = 2'd1,
        S_MEM  = 2'd2,
        S_LDWB = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     code_q, code_d;
    logic [DAW-1:0] daddr_q, daddr_d;
    logic [RAW-1:0] waddr_q, waddr_d;
    logic [2:0]     alus_q, alus_d;
    logic [DW-1:0]  alu_a_q, alu_a_d;
    logic [DW-1:0]  alu_b_q, alu_b_d;
    logic [DW-1:0]  alu_out_q, alu_out_d;
    logic [DW-1:0]  mux_out_q, mux_out_d;
    logic [1:0]     flags_q, flags_d;
    logic           done_q, done_d;

    logic [DW-1:0]  rf_q [C_RF_DEPTH];
    logic [DW-1:0]  rf_d [C_RF_DEPTH];
    logic [DW-1:0]  ram [C_RAM_DEPTH];
    logic [DW-1:0]  ram_rdata_q;

    logic           ram_we;
    logic           rf_we;
    logic [DW-1:0]  rf_wdata;
    logic [DW-1:0]  rd_a, rd_b;
    logic [DW:0]    alu_full;
    logic [DW-1:0]  alu_res;
    logic           alu_c;

    always_comb begin
        rd_a = rf_q[bus.RF_Ra_addr];
        rd_b = rf_q[bus.RF_Rb_addr];
        if (C_ZERO_REG && bus.RF_Ra_addr == '0) rd_a = '0;
        if (C_ZERO_REG && bus.RF_Rb_addr == '0) rd_b = '0;
    end

    // Carry/borrow lands in the extra top bit; logic ops leave it 0.
    always_comb begin
        alu_full = '0;
        case (alus_q)
            3'b000:  alu_full = {1'b0, alu_a_q} + {1'b0, alu_b_q};
            3'b001:  alu_full = {1'b0, alu_a_q} - {1'b0, alu_b_q};
            3'b010:  alu_full = {1'b0, alu_a_q & alu_b_q};
            3'b011:  alu_full = {1'b0, alu_a_q | alu_b_q};
            3'b100:  alu_full = {1'b0, alu_a_q ^ alu_b_q};
            3'b101:  alu_full = {1'b0, ~alu_a_q};
            3'b110:  alu_full = {alu_a_q, 1'b0};
            default: alu_full = {1'b0, alu_a_q};
        endcase
    end

    assign alu_res = alu_full[DW-1:0];
    assign alu_c   = alu_full[DW];

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        daddr_d   = daddr_q;
        waddr_d   = waddr_q;
        alus_d    = alus_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_out_d = alu_out_q;
        mux_out_d = mux_out_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = alu_res;
        ram_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Op_valid) begin
                    code_d  = bus.Op_code;
                    daddr_d = bus.D_addr;
                    waddr_d = bus.RF_W_addr;
                    alus_d  = bus.Alu_s;
                    alu_a_d = rd_a;
                    alu_b_d = rd_b;
                    state_d = (bus.Op_code == C_OP_LOAD) ? S_MEM : S_EX;
                end
            end
            S_EX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                ram_we  = (code_q == C_OP_STORE);
                if (code_q == C_OP_ALU) begin
                    rf_we     = 1'b1;
                    alu_out_d = alu_res;
                    mux_out_d = alu_res;
                    flags_d   = {alu_c, (alu_res == '0)};
                end
            end
            S_MEM: begin
                state_d = S_LDWB;
            end
            S_LDWB: begin
                done_d    = 1'b1;
                state_d   = S_IDLE;
                rf_we     = 1'b1;
                rf_wdata  = ram_rdata_q;
                mux_out_d = ram_rdata_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rf_d = rf_q;
        if (rf_we && !(C_ZERO_REG && waddr_q == '0)) rf_d[waddr_q] = rf_wdata;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            code_q    <= '0;
            daddr_q   <= '0;
            waddr_q   <= '0;
            alus_q    <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_out_q <= '0;
            mux_out_q <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < C_RF_DEPTH; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            daddr_q   <= daddr_d;
            waddr_q   <= waddr_d;
            alus_q    <= alus_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_out_q <= alu_out_d;
            mux_out_q <= mux_out_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            rf_q      <= rf_d;
        end
    end

    // RAM keeps its contents through reset; only a pending store is dropped.
    always_ff @(posedge Clock) begin
        if (ram_we && Reset) ram[daddr_q] <= alu_a_q;
        ram_rdata_q <= ram[daddr_q];
    end

    assign bus.Op_ready = (state_q == S_IDLE);
    assign bus.Done     = done_q;
    assign bus.Flags    = flags_q;
    assign bus.ALU_A    = alu_a_q;
    assign bus.ALU_B    = alu_b_q;
    assign bus.ALU_Out  = alu_out_q;
    assign bus.Mux_out  = mux_out_q;

    generate
        if (C_ZERO_REG) begin : g_rq0_zero
            assign bus.RQ0 = '0;
        end else begin : g_rq0_rf
            assign bus.RQ0 = rf_q[0];
        end
    endgenerate

endmodule
`default_nettype wire
